rv_div_ctrl: RTL and testbench
==============================

Name: rv_div_ctrl

Overview:
Issue and sequencing controller that sits between the EX stage and the 64-bit signed radix-4 SRT divider core. It decodes RV64M DIV/DIVU/REM/REMU and their *W forms, and resolves divide-by-zero and signed overflow without using the core. It adapts unsigned operands for the signed-only core, drives the core's vld/ready handshake, and returns a single architecturally correct 64-bit result. While an operation is in flight it stalls the pipeline.

Parameters:
XLEN, 64, datapath width; only 64 is supported.
BYPASS_LAT, 1, cycles from accept to res_vld_o for special-case (bypassed) ops; fixed at 1.

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
ex_vld_i  in  1  divide op present in EX
funct3_i  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
word_i  in  1  *W variant
rs1_i  in  64  dividend
rs2_i  in  64  divisor
flush_i  in  1  kill in-flight op
stall_o  out  1  EX must hold
res_vld_o  out  1  one-cycle result strobe
res_o  out  64  result
div_vld_o  out  1  request to core
div_op1_o  out  64  core dividend
div_op2_o  out  64  core divisor
div_ready_i  in  1  core ready (high while core idle)
div_quo_i  in  64  core quotient
div_rem_i  in  64  core remainder

Behaviour:
- Reset values: stall_o=0, res_vld_o=0, res_o=0, div_vld_o=0, div_op1_o=0, div_op2_o=0; FSM in IDLE. Asserting reset mid-operation returns to IDLE immediately and discards everything.
- Accept: in IDLE with ex_vld_i=1. Operands and op decode are latched. stall_o rises combinationally in the accept cycle and stays high until the res_vld_o cycle, inclusive.
- Operand prep:
  - word_i=1: signed ops sign-extend [31:0]; unsigned ops zero-extend [31:0].
  - Signed ops pass straight to the core.
  - Unsigned with op2[63]=1: bypass. q = (op1>=op2); r = op1 - q*op2.
  - Unsigned with op1[63]=1 and op2[63]=0: pre-shift. The core receives op1>>1, and FIX applies the correction.
  - Unsigned with op1[63]=0: direct to the core.
- Special cases, bypassed with result valid 1 cycle after accept:
  - op2==0: q = all ones, r = op1.
  - Signed overflow, op1 = most negative (of the effective width) and op2 = -1: q = op1, r = 0.
- States:
  - IDLE → BYP: on a special case.
  - IDLE → REQ: otherwise.
  - REQ: div_vld_o=1 with operands held. Goes to WAIT on the first cycle div_ready_i=0, which marks core acceptance.
  - WAIT: waits for div_ready_i to return to 1. The core outputs are valid in that cycle and are captured then. Goes to FIX if pre-shift was used, else OUT.
  - FIX: q = 2*q1; r = 2*r1 + op1[0]; if r >= op2 then q += 1 and r -= op2. Then OUT.
  - BYP/OUT: res_vld_o=1 and res_o selected, then IDLE.
- Result: REM* selects r, DIV* selects q. word_i=1 sign-extends res[31:0] to 64 bits for all four ops.
- flush_i:
  - In IDLE/BYP/OUT: suppresses res_vld_o.
  - In REQ before core acceptance: drop div_vld_o and go to IDLE.
  - In WAIT: go to DRAIN. DRAIN waits for div_ready_i=1 with no strobe, then IDLE, because the core cannot abort. stall_o drops on flush.
- A new accept is not possible in the res_vld_o cycle (FSM not in IDLE); back-to-back issue costs one bubble.

Optional Feature:
RV_DIV_REUSE_EN: when defined, the controller keeps the last operands, the word flag, the signedness and both q and r.
- A later op with identical operands, word flag and signedness (e.g. DIV then REM) completes in 1 cycle from the cache without a core request.
- The cache is invalidated on reset and by any flush during WAIT/DRAIN.
- When undefined, every non-special op uses the core.

Decomposition:
- rv_div_pkg holds:
  - funct3 constants: F3_DIV, F3_DIVU, F3_REM, F3_REMU.
  - FSM state encoding, one-hot: IDLE, BYP, REQ, WAIT, FIX, OUT, DRAIN.
  - XLEN_MIN constant (most negative value).
- Sub-module rv_div_fix: the combinational unsigned pre-shift correction (q1, r1, op1[0], op2 → q, r). It is unit-tested separately.

Test Plan:
- DIV, rs1=-7, rs2=2 → res=-3 via the core. REM with the same operands → -1.
- DIVU, rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=3 → pre-shift path gives 0x5555_5555_5555_5555. REMU with the same operands → 0.
- DIV with rs2=0 → 0xFFFF_FFFF_FFFF_FFFF one cycle after accept, no div_vld_o. REMU rs1=5, rs2=0 → 5. DIVW rs1=0x8000_0000, rs2=-1 → 0xFFFF_FFFF_8000_0000.
- DIVU, rs1=10, rs2=0x8000_0000_0000_0000 → 0 via bypass. REMU with the same operands → 10.
- Flush asserted two cycles into WAIT → no res_vld_o; FSM in DRAIN until div_ready_i=1. The next op after that returns the correct result.
- With RV_DIV_REUSE_EN: DIV 100/7 then REM 100/7 → 14, then 2. The second completes in 1 cycle with no div_vld_o.

Source files
------------

// File: rtl/rv_div_ctrl_pkg.sv
// rv_div_pkg: shared constants, FSM state encoding and the result-select
// helper for the RV64M divide controller (rv_div_ctrl) and its sub-modules.
//   F3_*      : funct3 encodings of DIV/DIVU/REM/REMU
//   XLEN_MIN  : most negative 64-bit value
//   WORD_MIN  : most negative 32-bit value, sign-extended to 64 bits
//   div_state_e : one-hot controller state
package rv_div_pkg;

    localparam int DIV_XLEN = 64;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [63:0] XLEN_MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] WORD_MIN = 64'hFFFF_FFFF_8000_0000;

    typedef enum logic [6:0] {
        IDLE  = 7'b000_0001,
        BYP   = 7'b000_0010,
        REQ   = 7'b000_0100,
        WAIT  = 7'b000_1000,
        FIX   = 7'b001_0000,
        OUT   = 7'b010_0000,
        DRAIN = 7'b100_0000
    } div_state_e;

    // REM* returns the remainder, DIV* the quotient; *W forms sign-extend
    // bit 31 of whichever was picked.
    function automatic logic [63:0] sel_res(input logic        is_rem,
                                            input logic        word,
                                            input logic [63:0] q,
                                            input logic [63:0] r);
        logic [63:0] v;
        v = is_rem ? r : q;
        return word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

endpackage

// File: rtl/rv_div_ctrl_if.sv
// rv_div_ctrl_if: request/response link between the divide controller and
// the signed radix-4 SRT divider core.
//   div_vld_o   : controller -> core, operation request
//   div_op1_o   : controller -> core, dividend
//   div_op2_o   : controller -> core, divisor
//   div_ready_i : core -> controller, high while the core is idle
//   div_quo_i   : core -> controller, quotient (valid when ready returns)
//   div_rem_i   : core -> controller, remainder (valid when ready returns)
// Modports: master = controller side, slave = core side.
interface rv_div_ctrl_if #(
    parameter int XLEN = 64
);
    logic            div_vld_o;
    logic [XLEN-1:0] div_op1_o;
    logic [XLEN-1:0] div_op2_o;
    logic            div_ready_i;
    logic [XLEN-1:0] div_quo_i;
    logic [XLEN-1:0] div_rem_i;

    modport master (
        output div_vld_o, div_op1_o, div_op2_o,
        input  div_ready_i, div_quo_i, div_rem_i
    );

    modport slave (
        input  div_vld_o, div_op1_o, div_op2_o,
        output div_ready_i, div_quo_i, div_rem_i
    );
endinterface

// File: rtl/rv_div_ctrl_fix.sv
// rv_div_fix: combinational correction for unsigned divides whose dividend
// had bit 63 set. The core divided op1>>1 by op2 giving q1/r1; this restores
// the full quotient/remainder by shifting the dropped LSB back in and doing
// one restoring step.
//   q1, r1  : core quotient/remainder of (op1>>1)/op2
//   op1_lsb : bit 0 of the original dividend
//   op2     : divisor (bit 63 clear on this path)
//   q, r    : corrected unsigned quotient/remainder of op1/op2
module rv_div_fix
    import rv_div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic [XLEN-1:0] q1,
    input  logic [XLEN-1:0] r1,
    input  logic            op1_lsb,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r
);
    // 2*r1+lsb kept one bit wider so the compare is exact for any width.
    logic [XLEN:0] r2;
    logic          inc;

    always_comb begin
        r2  = {r1, op1_lsb};
        inc = (r2 >= {1'b0, op2});
        q   = (q1 << 1) | {{(XLEN-1){1'b0}}, inc};
        // True remainder is below op2, so modular subtraction is exact.
        r   = inc ? (r2[XLEN-1:0] - op2) : r2[XLEN-1:0];
    end
endmodule

// File: rtl/rv_div_ctrl.sv
// rv_div_ctrl: EX-stage issue/sequencing controller for RV64M
// DIV/DIVU/REM/REMU and their *W forms in front of a signed-only 64-bit SRT
// divider core.
//   clk, rstn   : clock, asynchronous active-low reset
//   ex_vld_i    : divide op present in EX
//   funct3_i    : 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   word_i      : *W variant
//   rs1_i/rs2_i : dividend / divisor
//   flush_i     : kill in-flight op
//   stall_o     : EX must hold (combinational in the accept cycle)
//   res_vld_o   : one-cycle result strobe
//   res_o       : result
//   div         : core link (rv_div_ctrl_if.master)
// Divide-by-zero, signed overflow and unsigned divisors >= 2^63 complete
// without the core one cycle after accept. Unsigned dividends >= 2^63 are
// halved for the core and fixed up afterwards in rv_div_fix.
// Optional: `define RV_DIV_REUSE_EN keeps the last core result (q and r)
// so a matching DIV/REM pair completes the second op in one cycle.
module rv_div_ctrl
    import rv_div_pkg::*;
#(
    parameter int XLEN       = DIV_XLEN,
    parameter int BYPASS_LAT = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ex_vld_i,
    input  logic [2:0]      funct3_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            res_vld_o,
    output logic [XLEN-1:0] res_o,
    rv_div_ctrl_if.master   div
);

    if (XLEN != 64 || BYPASS_LAT != 1) begin : g_bad_cfg
        $error("rv_div_ctrl supports only XLEN=64 and BYPASS_LAT=1");
    end

    div_state_e      state;
    logic            res_vld_q, div_vld_q;
    logic            is_rem_q, word_q, pre_q, lsb_q;
    logic [XLEN-1:0] b_q, q1_q, r1_q;
    logic [XLEN-1:0] fix_q, fix_r;

    // ---------------- decode and operand preparation ----------------
    logic            go, accept, busy, sgn, is_rem;
    logic [XLEN-1:0] a, b, core_a, byp_q, byp_r;
    logic            div0, ovf, ubig, byp, pre;
    logic            hit;
    logic [XLEN-1:0] hit_q, hit_r;

    assign go     = ex_vld_i & (funct3_i inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU});
    assign sgn    = (funct3_i == F3_DIV) | (funct3_i == F3_REM);
    assign is_rem = (funct3_i == F3_REM) | (funct3_i == F3_REMU);
    assign accept = (state == IDLE) & go & ~flush_i;

    always_comb begin
        a = rs1_i;
        b = rs2_i;
        if (word_i) begin
            a = sgn ? {{(XLEN-32){rs1_i[31]}}, rs1_i[31:0]} : {{(XLEN-32){1'b0}}, rs1_i[31:0]};
            b = sgn ? {{(XLEN-32){rs2_i[31]}}, rs2_i[31:0]} : {{(XLEN-32){1'b0}}, rs2_i[31:0]};
        end
    end

    assign div0 = (b == '0);
    assign ovf  = sgn & (&b) & (a == (word_i ? WORD_MIN : XLEN_MIN));
    // Unsigned divisor >= 2^63: quotient can only be 0 or 1.
    assign ubig = ~sgn & b[XLEN-1];
    assign byp  = div0 | ovf | ubig;
    // Unsigned dividend >= 2^63 would read as negative in the signed core.
    assign pre    = ~sgn & a[XLEN-1] & ~b[XLEN-1];
    assign core_a = pre ? (a >> 1) : a;

    always_comb begin
        byp_q = '1;
        byp_r = a;
        if (div0) begin
            byp_q = '1;
            byp_r = a;
        end else if (ovf) begin
            byp_q = a;
            byp_r = '0;
        end else if (a >= b) begin
            byp_q = {{(XLEN-1){1'b0}}, 1'b1};
            byp_r = a - b;
        end else begin
            byp_q = '0;
            byp_r = a;
        end
    end

    rv_div_fix #(.XLEN(XLEN)) u_fix (
        .q1      (q1_q),
        .r1      (r1_q),
        .op1_lsb (lsb_q),
        .op2     (b_q),
        .q       (fix_q),
        .r       (fix_r)
    );

    // ---------------- outputs ----------------
    // DRAIN holds a newly presented op until the core has finished the
    // abandoned one; otherwise stall only covers the op's own lifetime.
    assign busy          = state inside {BYP, REQ, WAIT, FIX, OUT};
    assign stall_o       = ~flush_i & (busy | (go & ((state == IDLE) | (state == DRAIN))));
    assign res_vld_o     = res_vld_q & ~flush_i;
    assign div.div_vld_o = div_vld_q & ~flush_i;

    // ---------------- controller FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            res_vld_q     <= 1'b0;
            res_o         <= '0;
            div_vld_q     <= 1'b0;
            div.div_op1_o <= '0;
            div.div_op2_o <= '0;
            is_rem_q      <= 1'b0;
            word_q        <= 1'b0;
            pre_q         <= 1'b0;
            lsb_q         <= 1'b0;
            b_q           <= '0;
            q1_q          <= '0;
            r1_q          <= '0;
        end else begin
            res_vld_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        is_rem_q <= is_rem;
                        word_q   <= word_i;
                        pre_q    <= pre;
                        lsb_q    <= a[0];
                        b_q      <= b;
                        if (byp) begin
                            state     <= BYP;
                            res_vld_q <= 1'b1;
                            res_o     <= sel_res(is_rem, word_i, byp_q, byp_r);
                        end else if (hit) begin
                            state     <= OUT;
                            res_vld_q <= 1'b1;
                            res_o     <= sel_res(is_rem, word_i, hit_q, hit_r);
                        end else begin
                            state         <= REQ;
                            div_vld_q     <= 1'b1;
                            div.div_op1_o <= core_a;
                            div.div_op2_o <= b;
                        end
                    end
                end
                // ready falling is the core's acceptance of the request
                REQ: begin
                    if (!div.div_ready_i) begin
                        div_vld_q <= 1'b0;
                        state     <= flush_i ? DRAIN : WAIT;
                    end else if (flush_i) begin
                        div_vld_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WAIT: begin
                    if (div.div_ready_i) begin
                        if (flush_i) begin
                            state <= IDLE;
                        end else if (pre_q) begin
                            q1_q  <= div.div_quo_i;
                            r1_q  <= div.div_rem_i;
                            state <= FIX;
                        end else begin
                            res_o     <= sel_res(is_rem_q, word_q, div.div_quo_i, div.div_rem_i);
                            res_vld_q <= 1'b1;
                            state     <= OUT;
                        end
                    end else if (flush_i) begin
                        state <= DRAIN;
                    end
                end
                FIX: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        res_o     <= sel_res(is_rem_q, word_q, fix_q, fix_r);
                        res_vld_q <= 1'b1;
                        state     <= OUT;
                    end
                end
                BYP, OUT: state <= IDLE;
                // the core cannot abort; wait it out with no strobe
                DRAIN: if (div.div_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- optional result reuse ----------------
`ifdef RV_DIV_REUSE_EN
    logic            c_vld, c_word, c_sgn, sgn_q, core_done, inval;
    logic [XLEN-1:0] a_q, c_a, c_b, c_q, c_r;

    assign core_done = (state == WAIT) & div.div_ready_i & ~flush_i & ~pre_q;
    assign inval     = flush_i & ((state == WAIT) | (state == DRAIN) |
                                  ((state == REQ) & ~div.div_ready_i));
    assign hit   = c_vld & (c_a == a) & (c_b == b) & (c_word == word_i) & (c_sgn == sgn);
    assign hit_q = c_q;
    assign hit_r = c_r;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_vld  <= 1'b0;
            c_word <= 1'b0;
            c_sgn  <= 1'b0;
            sgn_q  <= 1'b0;
            a_q    <= '0;
            c_a    <= '0;
            c_b    <= '0;
            c_q    <= '0;
            c_r    <= '0;
        end else begin
            if (accept) begin
                a_q   <= a;
                sgn_q <= sgn;
            end
            if (inval) begin
                c_vld <= 1'b0;
            end else if (core_done | (state == FIX)) begin
                c_vld  <= 1'b1;
                c_a    <= a_q;
                c_b    <= b_q;
                c_word <= word_q;
                c_sgn  <= sgn_q;
                c_q    <= core_done ? div.div_quo_i : fix_q;
                c_r    <= core_done ? div.div_rem_i : fix_r;
            end
        end
    end
`else
    assign hit   = 1'b0;
    assign hit_q = '0;
    assign hit_r = '0;
`endif

endmodule

// File: tb/tb_rv_div_ctrl.sv
// tb_rv_div_ctrl: self-checking bench for rv_div_ctrl. A behavioural divider
// core answers requests after a random latency; every result is compared
// against an RV64M reference computed with plain arithmetic. Directed cases
// cover the special-case paths, pre-shift, flush/drain, mid-op reset and
// (with RV_DIV_REUSE_EN) result reuse; a random loop covers the rest.
module tb_rv_div_ctrl;
    import rv_div_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ex_vld = 1'b0;
    logic [2:0]  funct3 = F3_DIV;
    logic        word = 1'b0;
    logic [63:0] rs1 = '0;
    logic [63:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        stall, res_vld;
    logic [63:0] res;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    int lat_min = 1;

    // behavioural core
    logic        core_rdy;
    logic [63:0] core_q, core_r;
    int          core_cnt;

    rv_div_ctrl_if #(.XLEN(64)) div_if ();

    assign div_if.div_ready_i = core_rdy;
    assign div_if.div_quo_i   = core_q;
    assign div_if.div_rem_i   = core_r;

    rv_div_ctrl #(.XLEN(64), .BYPASS_LAT(1)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ex_vld_i  (ex_vld),
        .funct3_i  (funct3),
        .word_i    (word),
        .rs1_i     (rs1),
        .rs2_i     (rs2),
        .flush_i   (flush),
        .stall_o   (stall),
        .res_vld_o (res_vld),
        .res_o     (res),
        .div       (div_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_rdy <= 1'b1;
            core_cnt <= 0;
            core_q   <= '0;
            core_r   <= '0;
        end else if (core_rdy) begin
            if (div_if.div_vld_o) begin
                core_rdy <= 1'b0;
                core_cnt <= $urandom_range(lat_min, lat_min + 3);
                core_q   <= $signed(div_if.div_op1_o) / $signed(div_if.div_op2_o);
                core_r   <= $signed(div_if.div_op1_o) % $signed(div_if.div_op2_o);
            end
        end else begin
            core_cnt <= core_cnt - 1;
            if (core_cnt <= 1) core_rdy <= 1'b1;
        end
    end

    always @(negedge clk) if (div_if.div_vld_o) vld_cnt <= vld_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // RV64M architectural result
    function automatic logic [63:0] ref_res(input logic [2:0] f3, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] sa32, sb32;
        logic [31:0] r32;
        logic [63:0] r64;
        logic uns, rem;
        uns = f3[0];
        rem = f3[1];
        if (w) begin
            sa32 = a[31:0];
            sb32 = b[31:0];
            if (b[31:0] == 32'h0)
                r32 = rem ? a[31:0] : 32'hFFFF_FFFF;
            else if (!uns && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                r32 = rem ? 32'h0 : 32'h8000_0000;
            else if (uns)
                r32 = rem ? (a[31:0] % b[31:0]) : (a[31:0] / b[31:0]);
            else
                r32 = rem ? (sa32 % sb32) : (sa32 / sb32);
            return {{32{r32[31]}}, r32};
        end
        sa = a;
        sb = b;
        if (b == 64'h0)
            r64 = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (!uns && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
            r64 = rem ? 64'h0 : a;
        else if (uns)
            r64 = rem ? (a % b) : (a / b);
        else
            r64 = rem ? (sa % sb) : (sa / sb);
        return r64;
    endfunction

    // ops that must finish without the core
    function automatic bit ref_special(input logic [2:0] f3, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        if (w)
            return (b[31:0] == 32'h0) ||
                   (!f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'h0) ||
               (!f3[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) ||
               (f3[0] && b[63]);
    endfunction

    function automatic logic [63:0] pick_opnd();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0: v = 64'h0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'h8000_0000_0000_0000;
            3: v = {$urandom, 32'h8000_0000};
            4: v = {32'h0, $urandom};
            5: v = 64'($urandom_range(0, 20));
            6: v = v | 64'h8000_0000_0000_0000;
            7: v = {$urandom, 32'hFFFF_FFFF};
            default: ;
        endcase
        return v;
    endfunction

    task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output int lat, output int nvld);
        logic [63:0] exp;
        bit stall_ok;
        int v0;
        exp = ref_res(f3, w, a, b);
        @(negedge clk);
        funct3 = f3; word = w; rs1 = a; rs2 = b; ex_vld = 1'b1;
        #1 chk("stall_accept", stall, 1'b1);
        v0 = vld_cnt;
        @(negedge clk);
        // scramble inputs to prove the op was latched
        ex_vld = 1'b0; rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
        word = 1'($urandom); funct3 = 3'($urandom_range(4, 7));
        lat = 1;
        stall_ok = 1;
        while (!res_vld && lat < 100) begin
            if (!stall) stall_ok = 0;
            @(negedge clk);
            lat++;
        end
        if (!stall) stall_ok = 0;
        chk("res_vld", res_vld, 1'b1);
        chk("res", res, exp);
        chk("stall_hold", stall_ok, 1'b1);
        @(negedge clk);
        chk("strobe_1cyc", res_vld, 1'b0);
        nvld = vld_cnt - v0;
        if (ref_special(f3, w, a, b)) begin
            chk("byp_lat", lat, 1);
            chk("byp_novld", nvld, 0);
        end
    endtask

    initial begin
        int lat, nv, n;
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_stall", stall, 1'b0);
        chk("rst_res_vld", res_vld, 1'b0);
        chk("rst_res", res, 64'h0);
        chk("rst_div_vld", div_if.div_vld_o, 1'b0);
        chk("rst_op1", div_if.div_op1_o, 64'h0);
        chk("rst_op2", div_if.div_op2_o, 64'h0);
        rstn = 1'b1;

        // directed cases with literal expectations
        do_op(F3_DIV, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, nv);
        chk("div_m7_2", res, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_m7_2_core", (nv > 0), 1'b1);
        do_op(F3_REM, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, nv);
        chk("rem_m7_2", res, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(F3_DIVU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, lat, nv);
        chk("divu_pre", res, 64'h5555_5555_5555_5555);
        do_op(F3_REMU, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, lat, nv);
        chk("remu_pre", res, 64'h0);
        do_op(F3_DIV, 0, 64'd1234, 64'd0, lat, nv);
        chk("div_by0", res, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(F3_REMU, 0, 64'd5, 64'd0, lat, nv);
        chk("remu_by0", res, 64'd5);
        do_op(F3_DIV, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, nv);
        chk("divw_ovf", res, 64'hFFFF_FFFF_8000_0000);
        do_op(F3_DIVU, 0, 64'd10, 64'h8000_0000_0000_0000, lat, nv);
        chk("divu_big", res, 64'h0);
        do_op(F3_REMU, 0, 64'd10, 64'h8000_0000_0000_0000, lat, nv);
        chk("remu_big", res, 64'd10);

        // flush two cycles into WAIT, core must drain
        lat_min = 5;
        @(negedge clk);
        funct3 = F3_DIV; word = 0; rs1 = 64'd1000; rs2 = 64'd7; ex_vld = 1'b1;
        @(negedge clk);
        ex_vld = 1'b0;
        n = 0;
        while (core_rdy && n < 20) begin @(negedge clk); n++; end
        chk("flush_core_acc", core_rdy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_stall", stall, 1'b0);
        @(negedge clk);
        flush = 1'b0; funct3 = F3_DIV; rs1 = 64'd9; rs2 = 64'd3; ex_vld = 1'b1;
        #1 chk("drain_hold", stall, 1'b1);
        @(negedge clk);
        ex_vld = 1'b0;
        seen = 0; n = 0;
        while (!core_rdy && n < 30) begin
            if (res_vld || div_if.div_vld_o) seen = 1;
            @(negedge clk); n++;
        end
        chk("drain_done", core_rdy, 1'b1);
        repeat (2) begin
            if (res_vld || div_if.div_vld_o) seen = 1;
            @(negedge clk);
        end
        chk("flush_nostrobe", seen, 1'b0);
        lat_min = 1;
        do_op(F3_DIV, 0, 64'd1000, 64'd7, lat, nv);
        chk("after_flush", res, 64'd142);

        // reset in the middle of an op
        lat_min = 5;
        @(negedge clk);
        funct3 = F3_REM; word = 0; rs1 = 64'd12345; rs2 = 64'd11; ex_vld = 1'b1;
        @(negedge clk);
        ex_vld = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_res", res, 64'h0);
        chk("mid_rst_div_vld", div_if.div_vld_o, 1'b0);
        chk("mid_rst_op1", div_if.div_op1_o, 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        lat_min = 1;
        do_op(F3_REM, 0, 64'd12345, 64'd11, lat, nv);
        chk("after_rst", res, 64'd3);

        // reuse: DIV then REM on the same operands
        do_op(F3_DIV, 0, 64'd100, 64'd7, lat, nv);
        chk("reuse_div", res, 64'd14);
        do_op(F3_REM, 0, 64'd100, 64'd7, lat, nv);
        chk("reuse_rem", res, 64'd2);
`ifdef RV_DIV_REUSE_EN
        chk("reuse_lat", lat, 1);
        chk("reuse_novld", nv, 0);
`else
        chk("noreuse_core", (nv > 0), 1'b1);
`endif

        // random ops
        for (int i = 0; i < 250; i++) begin
            lat_min = $urandom_range(1, 3);
            do_op(3'($urandom_range(4, 7)), 1'($urandom), pick_opnd(), pick_opnd(), lat, nv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
